// File: rtl/pwm_ctrl_pkg.sv
// Shared types and defaults for the PWM pulse-width decode controller.
// Holds the controller state encoding, symbol/sample widths and default parameter values.
package pwm_ctrl_pkg;

  localparam int SYM_W  = 8;
  localparam int DATA_W = 16;

  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_SETTLE_CYC = 2;
  localparam int DEF_IDLE_MIN   = 8;
  localparam int DEF_MAX_WIDTH  = 255;

  typedef enum logic [2:0] {
    ST_ARM,
    ST_WAIT_EDGE,
    ST_PULSE,
    ST_SETTLE,
    ST_COMMIT,
    ST_CLEAR
  } ctrl_state_t;

  // Bits needed to hold the values 0..max_val (never less than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sym_fifo.sv
// Small synchronous show-ahead FIFO for decoded symbols; head is visible while not empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sym_fifo
  import pwm_ctrl_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int WIDTH = SYM_W
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign count   = count_reg;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Gate the head so an empty FIFO presents zero rather than stale storage.
  assign head    = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/pwm_decode_ctrl.sv
// Threshold-based pulse detector that gates an external width counter, captures the
// resulting symbol after a settle delay and queues it, with sticky timeout/overflow flags.
module pwm_decode_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int IDLE_MIN   = DEF_IDLE_MIN,
  parameter int MAX_WIDTH  = DEF_MAX_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic signed [DATA_W-1:0] ref_in,
  input  logic signed [SYM_W-1:0]  decoded_symbol,
  output logic                     enable_counter,
  output logic                     counter_clear,
  output logic signed [SYM_W-1:0]  sym_data,
  output logic                     sym_valid,
  input  logic                     sym_ready,
  input  logic                     clear_flags,
  output logic                     err_timeout,
  output logic                     err_overflow
);

  localparam int IW = cnt_width(IDLE_MIN);
  localparam int WW = cnt_width(MAX_WIDTH);
  localparam int SW = cnt_width(SETTLE_CYC);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ctrl_state_t   state_reg;
  logic [IW-1:0] idle_cnt_reg;
  logic [WW-1:0] width_reg;
  logic [SW-1:0] settle_cnt_reg;

  logic          above;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          overflow_evt;
  logic          timeout_evt;

  // Signed strict compare: a sample equal to the threshold is idle.
  assign above        = (data_in > ref_in);
  assign pop          = sym_ready && !fifo_empty;
  assign sym_valid    = (fifo_count != '0);
  assign push         = (state_reg == ST_COMMIT);
  assign overflow_evt = push && fifo_full && !pop;
  // The above sample that would bring the width up to MAX_WIDTH aborts the pulse.
  assign timeout_evt  = (state_reg == ST_PULSE) && above &&
                        (width_reg == WW'(MAX_WIDTH - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_ARM;
      idle_cnt_reg   <= '0;
      width_reg      <= '0;
      settle_cnt_reg <= '0;
      enable_counter <= 1'b0;
      counter_clear  <= 1'b0;
    end else begin
      enable_counter <= 1'b0;
      counter_clear  <= 1'b0;
      case (state_reg)
        ST_ARM: begin
          if (above) begin
            idle_cnt_reg <= '0;
          end else begin
            idle_cnt_reg <= idle_cnt_reg + 1'b1;
            if (idle_cnt_reg == IW'(IDLE_MIN - 1)) state_reg <= ST_WAIT_EDGE;
          end
        end
        ST_WAIT_EDGE: begin
          if (above) begin
            state_reg      <= ST_PULSE;
            width_reg      <= WW'(1);
            enable_counter <= 1'b1;
          end
        end
        ST_PULSE: begin
          if (above) begin
            width_reg <= width_reg + 1'b1;
            if (timeout_evt) begin
              state_reg     <= ST_CLEAR;
              counter_clear <= 1'b1;
            end else begin
              enable_counter <= 1'b1;
            end
          end else begin
            state_reg      <= ST_SETTLE;
            settle_cnt_reg <= '0;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_reg == SW'(SETTLE_CYC - 1)) state_reg <= ST_COMMIT;
          else settle_cnt_reg <= settle_cnt_reg + 1'b1;
        end
        ST_COMMIT: begin
          state_reg     <= ST_CLEAR;
          counter_clear <= 1'b1;
        end
        ST_CLEAR: begin
          idle_cnt_reg <= '0;
          width_reg    <= '0;
          state_reg    <= ST_ARM;
        end
        default: state_reg <= ST_ARM;
      endcase
    end
  end

  // A new error in the same cycle as clear_flags keeps the flag set.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_timeout  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      err_timeout  <= timeout_evt  | (err_timeout  & ~clear_flags);
      err_overflow <= overflow_evt | (err_overflow & ~clear_flags);
    end
  end

  sym_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SYM_W)
  ) u_sym_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (decoded_symbol),
    .pop       (pop),
    .head      (sym_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
